demux_frame_ctrl: RTL and testbench
===================================

// Module: demux_frame_ctrl
// PURPOSE
//  Sequences the registered demux (DWIDTH x OUTPUTS lane register) as a serial-to-parallel frame assembler.
//  Accepts a valid/ready word stream and writes successive words to lanes 0,1,2,... via dmx_en/dmx_sel.
//  Presents a completed (or flushed partial) frame to the consumer and holds it until acknowledged.
//  Sits between a streaming source and any wide parallel consumer; carries no data itself.
// PARAMETERS
//  OUTPUTS   4   number of demux lanes (>=2); SW = $clog2(OUTPUTS), CW = $clog2(OUTPUTS+1)
//  CNT_W     16  width of completed-frame counter
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  in_valid     in   1       source word valid
//  in_ready     out  1       controller can accept a word this cycle
//  lanes        in   CW      words per frame; sampled at first accept of a frame
//  flush        in   1       close current partial frame
//  frame_ack    in   1       consumer has taken the presented frame
//  dmx_en       out  1       demux write enable (combinational)
//  dmx_sel      out  SW      demux lane select (combinational)
//  frame_valid  out  1       demux outputs hold a complete/flushed frame
//  frame_words  out  CW      number of valid lanes in presented frame (lanes 0..frame_words-1)
//  frame_cnt    out  CNT_W   frames presented since reset, wraps
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, ptr=0, lanes_q=OUTPUTS, frame_valid=0, frame_words=0,
//   frame_cnt=0; in_ready=0 while rst high; dmx_en=0.
//  States: IDLE (no word of frame yet), FILL (1..lanes_q-1 words written), HOLD (frame presented).
//  in_ready = (state != HOLD). accept = in_valid & in_ready.
//  dmx_en = accept; dmx_sel = ptr (0 in IDLE). Demux registers the word on the same edge.
//  lanes clamp: lanes==0 or lanes>OUTPUTS -> OUTPUTS. Captured into lanes_q on IDLE accept;
//   changes to lanes during FILL/HOLD have no effect on current frame.
//  IDLE: accept -> ptr=1, FILL; if effective lanes==1 -> HOLD directly. flush ignored.
//  FILL: accept -> ptr+1; accept with ptr==lanes_q-1 -> HOLD, frame_words=lanes_q.
//   flush without accept -> HOLD, frame_words=ptr. flush with accept (not last) -> HOLD,
//   frame_words=ptr+1 (word is kept). flush with last accept -> same as plain completion.
//  Entering HOLD: frame_valid=1 from the next cycle (same cycle demux q shows the last word),
//   frame_cnt increments by 1 on the transition edge. Latency last accept -> frame_valid = 1 cycle.
//  HOLD: in_ready=0, no demux writes, frame_valid/frame_words stable; flush ignored.
//   frame_ack=1 -> IDLE, ptr=0, frame_valid=0 and frame_words=0 next cycle; first new accept
//   possible the cycle after ack (no accept in ack cycle). frame_ack outside HOLD ignored.
//  Lanes >= frame_words in a partial frame keep stale data; consumer must use frame_words.
//  ptr never exceeds lanes_q-1; dmx_sel never exceeds OUTPUTS-1 (non-power-of-2 OUTPUTS safe).
//  rst mid-frame: frame discarded, returns to reset values immediately; demux contents not cleared.
//  frame_cnt wraps 2^CNT_W-1 -> 0.
// TESTING
//  1 Reset: rst pulse mid-FILL -> frame_valid=0, in_ready=0 during rst, in_ready=1 after, frame_cnt=0.
//  2 Full frame, OUTPUTS=4, lanes=4, words A,B,C,D back-to-back -> dmx_sel 0,1,2,3, frame_valid
//    next cycle, frame_words=4, q={D,C,B,A}, in_ready=0 until ack; ack -> IDLE, frame_cnt=1.
//  3 Flush: 2 words then flush alone -> frame_words=2; flush with 3rd accept -> frame_words=3;
//    flush in IDLE/HOLD -> no state change.
//  4 Lanes clamp/capture: lanes=0 -> 4-word frame; lanes=1 -> every accept goes to HOLD;
//    change lanes 4->2 mid-FILL -> current frame still 4 words.
//  5 Backpressure: hold frame_ack low 10 cycles with in_valid=1 -> no dmx_en, frame stable;
//    ack -> next word written to lane 0 one cycle later.
//  6 Non-pow2 OUTPUTS=3, random in_valid/ack over 1000 frames -> dmx_sel<=2, frame_cnt matches model.

Source files
------------

// File: rtl/demux_frame_ctrl.sv
// demux_frame_ctrl: sequences a registered demux as a serial-to-parallel frame assembler
module demux_frame_ctrl #(
  parameter int OUTPUTS = 4,
  parameter int CNT_W = 16,
  localparam int SW = $clog2(OUTPUTS),
  localparam int CW = $clog2(OUTPUTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    lanes,
  input  logic             flush,
  input  logic             frame_ack,
  output logic             dmx_en,
  output logic [SW-1:0]    dmx_sel,
  output logic             frame_valid,
  output logic [CW-1:0]    frame_words,
  output logic [CNT_W-1:0] frame_cnt
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  localparam logic [CW-1:0] MAXL = CW'(OUTPUTS);
  state_t state;
  logic [CW-1:0] ptr, ptr_nx, lanes_q, eff;
  logic accept, last;
  assign in_ready = (state != HOLD) & ~rst;
  assign accept = in_valid & in_ready;
  assign dmx_en = accept;
  assign dmx_sel = ptr[SW-1:0];
  assign eff = (lanes == '0 || lanes > MAXL) ? MAXL : lanes;
  assign ptr_nx = ptr + CW'(1);
  assign last = ptr_nx == lanes_q;
  // frame sequencing: fill lanes in order, present on completion or flush, wait for ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      lanes_q <= MAXL;
      frame_valid <= 1'b0;
      frame_words <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lanes_q <= eff;
          if (eff == CW'(1)) begin
            state <= HOLD;
            frame_valid <= 1'b1;
            frame_words <= CW'(1);
            frame_cnt <= frame_cnt + CNT_W'(1);
          end else begin
            ptr <= CW'(1);
            state <= FILL;
          end
        end
        FILL: if (accept & ~last & ~flush) begin
          ptr <= ptr_nx;
        end else if (accept | flush) begin
          state <= HOLD;
          ptr <= '0;
          frame_valid <= 1'b1;
          frame_words <= accept ? ptr_nx : ptr;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
        HOLD: if (frame_ack) begin
          state <= IDLE;
          frame_valid <= 1'b0;
          frame_words <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demux_frame_ctrl.sv
// tb_demux_frame_ctrl: directed and random checks of the frame controller against a frame-level model
module tb_demux_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, frame_ack = 1'b0;
  logic [2:0] lanes = 3'd4;
  logic [7:0] din = 8'd0;
  logic ir0, en0, fv0, ir1, en1, fv1;
  logic [1:0] sel0, sel1, fw1;
  logic [2:0] fw0;
  logic [15:0] fc0;
  logic [3:0] fc1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  demux_frame_ctrl #(.OUTPUTS(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .lanes(lanes),
    .flush(flush), .frame_ack(frame_ack), .dmx_en(en0), .dmx_sel(sel0),
    .frame_valid(fv0), .frame_words(fw0), .frame_cnt(fc0));
  demux_frame_ctrl #(.OUTPUTS(3), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .lanes(lanes[1:0]),
    .flush(flush), .frame_ack(frame_ack), .dmx_en(en1), .dmx_sel(sel1),
    .frame_valid(fv1), .frame_words(fw1), .frame_cnt(fc1));

  // lane registers the controller drives
  logic [7:0] dq [2][4];
  always @(posedge clk) begin
    if (en0) dq[0][sel0] <= din;
    if (en1) dq[1][sel1] <= din;
  end

  task automatic chk(input string n, input int k, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", n, k, a, e, $time);
    end
  endtask

  // frame-level model: words collected, frame target, presented frame
  int nw[2], tgt[2], pw[2], cnt[2], nfr[2], wv;
  bit pres[2];
  logic [7:0] lx [2][4];
  function automatic int eff(input int k, input int l);
    int m, v;
    m = (k != 0) ? 3 : 4;
    v = (k != 0) ? (l % 4) : l;
    return (v == 0 || v > m) ? m : v;
  endfunction
  task automatic present(input int k);
    pres[k] = 1'b1;
    pw[k] = nw[k];
    nw[k] = 0;
    cnt[k] = (cnt[k] + 1) % ((k != 0) ? 16 : 65536);
    nfr[k]++;
  endtask
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        pres[k] = 1'b0; nw[k] = 0; pw[k] = 0; cnt[k] = 0;
      end else if (pres[k]) begin
        if (frame_ack) pres[k] = 1'b0;
      end else if (in_valid) begin
        wv = nw[k];
        if (wv == 0) tgt[k] = eff(k, int'(lanes));
        lx[k][wv] = din;
        nw[k] = wv + 1;
        if (nw[k] == tgt[k] || (flush && wv > 0)) present(k);
      end else if (flush && nw[k] > 0) present(k);

  // per-cycle comparison against the model
  int a_ir, a_en, a_sel, a_fv, a_fw, a_fc, e_en;
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      a_ir = (k != 0) ? int'(ir1) : int'(ir0);
      a_en = (k != 0) ? int'(en1) : int'(en0);
      a_sel = (k != 0) ? int'(sel1) : int'(sel0);
      a_fv = (k != 0) ? int'(fv1) : int'(fv0);
      a_fw = (k != 0) ? int'(fw1) : int'(fw0);
      a_fc = (k != 0) ? int'(fc1) : int'(fc0);
      e_en = (!rst && !pres[k] && in_valid) ? 1 : 0;
      chk("in_ready", k, a_ir, (!rst && !pres[k]) ? 1 : 0);
      chk("dmx_en", k, a_en, e_en);
      if (e_en != 0) chk("dmx_sel", k, a_sel, nw[k]);
      chk("frame_valid", k, a_fv, int'(pres[k]));
      chk("frame_words", k, a_fw, pres[k] ? pw[k] : 0);
      chk("frame_cnt", k, a_fc, cnt[k]);
      if (pres[k]) for (int i = 0; i < pw[k]; i++) chk("lane_data", k * 10 + i, int'(dq[k][i]), int'(lx[k][i]));
    end

  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] l, input logic f, input logic a);
    @(posedge clk);
    #1;
    in_valid = v; din = d; lanes = l; flush = f; frame_ack = a;
    @(negedge clk);
  endtask
  task automatic ack_idle();
    step(0, 0, 4, 0, 1);
    step(0, 0, 4, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_in_ready", 0, int'(ir0), 0);
    chk("rst_cnt", 0, int'(fc0), 0);
    @(posedge clk); #1 rst = 1'b0;
    // full frame
    step(1, 8'hA1, 4, 0, 0); chk("t2_sel", 0, int'(sel0), 0); chk("t2_en", 0, int'(en0), 1);
    step(1, 8'hB2, 4, 0, 0); chk("t2_sel", 1, int'(sel0), 1);
    step(1, 8'hC3, 4, 0, 0); chk("t2_sel", 2, int'(sel0), 2);
    step(1, 8'hD4, 4, 0, 0); chk("t2_sel", 3, int'(sel0), 3);
    step(0, 0, 4, 0, 0);
    chk("t2_fv", 0, int'(fv0), 1); chk("t2_fw", 0, int'(fw0), 4); chk("t2_ready", 0, int'(ir0), 0);
    chk("t2_q0", 0, int'(dq[0][0]), 'hA1); chk("t2_q3", 0, int'(dq[0][3]), 'hD4);
    chk("t2_cnt", 0, int'(fc0), 1); chk("t2_fw_n3", 1, int'(fw1), 3);
    step(0, 0, 4, 0, 1); chk("t2_fv_ackcyc", 0, int'(fv0), 1);
    step(0, 0, 4, 0, 0); chk("t2_fv_after", 0, int'(fv0), 0); chk("t2_ready_after", 0, int'(ir0), 1);
    // flush
    step(1, 8'h15, 4, 0, 0); step(1, 8'h16, 4, 0, 0); step(0, 0, 4, 1, 0);
    step(0, 0, 4, 0, 0); chk("t3_fw2", 0, int'(fw0), 2);
    ack_idle();
    step(1, 8'h17, 4, 0, 0); step(1, 8'h18, 4, 0, 0); step(1, 8'h19, 4, 1, 0);
    step(0, 0, 4, 0, 0); chk("t3_fw3", 0, int'(fw0), 3); chk("t3_q2", 0, int'(dq[0][2]), 'h19);
    ack_idle();
    step(0, 0, 4, 1, 0); step(0, 0, 4, 0, 0); chk("t3_idle_flush", 0, int'(fv0), 0);
    step(1, 8'h1A, 4, 1, 0); step(0, 0, 4, 0, 0); chk("t3_idle_acc_flush", 0, int'(fv0), 0);
    step(0, 0, 4, 1, 0); step(0, 0, 4, 0, 0); chk("t3_fw1", 0, int'(fw0), 1);
    step(0, 0, 4, 1, 0); chk("t3_hold_flush", 0, int'(fw0), 1);
    ack_idle();
    // lanes clamp and capture
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0); chk("t4_lanes0", 0, int'(fw0), 4); chk("t4_lanes0_n3", 1, int'(fw1), 3);
    ack_idle();
    step(1, 8'h30, 1, 0, 0); step(0, 0, 1, 0, 0); chk("t4_lanes1_fv", 0, int'(fv0), 1); chk("t4_lanes1_fw", 0, int'(fw0), 1);
    ack_idle();
    step(1, 8'h40, 4, 0, 0); step(1, 8'h41, 2, 0, 0); step(1, 8'h42, 2, 0, 0); step(1, 8'h43, 2, 0, 0);
    step(0, 0, 2, 0, 0); chk("t4_capture", 0, int'(fw0), 4);
    ack_idle();
    // reset mid-fill
    step(1, 8'h50, 4, 0, 0); step(1, 8'h51, 4, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t1_ready_rst", 0, int'(ir0), 0); chk("t1_fv_rst", 0, int'(fv0), 0); chk("t1_cnt_rst", 0, int'(fc0), 0);
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("t1_ready_after", 0, int'(ir0), 1);
    step(1, 8'h60, 4, 0, 0); chk("t1_sel_fresh", 0, int'(sel0), 0);
    for (int i = 1; i < 4; i++) step(1, 8'(8'h60 + i), 4, 0, 0);
    step(0, 0, 4, 0, 0); chk("t1_fw", 0, int'(fw0), 4);
    // backpressure
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h70 + i), 4, 0, 0);
      chk("t5_no_en", i, int'(en0), 0);
      chk("t5_stable", i, int'(dq[0][0]), 'h60);
    end
    step(1, 8'h7A, 4, 0, 1); chk("t5_ack_no_en", 0, int'(en0), 0);
    step(1, 8'h7B, 4, 0, 0); chk("t5_en", 0, int'(en0), 1); chk("t5_sel", 0, int'(sel0), 0);
    // random traffic
    for (int c = 0; c < 60000 && (nfr[0] < 1000 || nfr[1] < 1000); c++)
      step($urandom_range(0, 9) < 7, 8'($urandom), 3'($urandom_range(0, 4)), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
    chk("t6_frames", 1, (nfr[1] >= 1000 && nfr[0] >= 1000) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
